imm_gen_stage: RTL and testbench

- Registered, parametrised immediate-generation stage between instruction fetch/decode and register-read/execute.
- Takes the instruction's upper 25 bits (instr[31:7]) plus an immediate-format select, and produces a sign- or zero-extended immediate of DATA_WIDTH bits.
- Supports all RISC-V base formats, including J, with an illegal-format flag.
- Results are queued in a small DEPTH-entry output FIFO with valid/ready handshakes on both sides, so decode stalls are absorbed without back-pressuring fetch every cycle.

---
 rtl/imm_gen_stage.sv | 95 +++++++++
 tb/tb_imm_gen_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered RISC-V immediate generator with DEPTH-entry output FIFO
// Optional macro IMM_ZIMM_EN: ImmType 101 decodes the CSR zimm (rs1 field) instead of flagging illegal.
module imm_gen_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [24:0]               imm,
  input  logic [2:0]                ImmType,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     ImmOut,
  output logic                      ImmErr,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]           imm32;
  logic                  dec_err;
  logic [DATA_WIDTH-1:0] dec_imm;

  always_comb begin
    imm32   = '0;
    dec_err = 1'b0;
    case (ImmType)
      3'b000: imm32 = {{20{imm[24]}}, imm[24:13]};
      3'b001: imm32 = {{20{imm[24]}}, imm[24:18], imm[4:0]};
      3'b010: imm32 = {{19{imm[24]}}, imm[24], imm[0], imm[23:18], imm[4:1], 1'b0};
      3'b011: imm32 = {imm[24:5], 12'b0};
      3'b100: imm32 = {{11{imm[24]}}, imm[24], imm[12:5], imm[13], imm[23:14], 1'b0};
`ifdef IMM_ZIMM_EN
      3'b101: imm32 = {27'b0, imm[12:8]};
`endif
      default: dec_err = 1'b1;
    endcase
    // Every format widens from bit 31 of its RV32 value; zimm has bit 31 clear.
    dec_imm        = {DATA_WIDTH{imm32[31]}};
    dec_imm[31:0]  = imm32;
    if (dec_err) dec_imm = '0;
  end

  logic [DATA_WIDTH-1:0] mem_imm [DEPTH];
  logic                  mem_err [DEPTH];
  logic [TAG_WIDTH-1:0]  mem_tag [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;

  assign in_ready  = rst_n && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign ImmOut  = mem_imm[rd_ptr];
  assign ImmErr  = mem_err[rd_ptr];
  assign out_tag = mem_tag[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_imm[i] <= '0;
        mem_err[i] <= 1'b0;
        mem_tag[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_imm[wr_ptr] <= dec_imm;
        mem_err[wr_ptr] <= dec_err;
        mem_tag[wr_ptr] <= in_tag;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - directed and random checks of imm_gen_stage (32- and 64-bit instances)
module tb_imm_gen_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [24:0] imm;
  logic [2:0]  imm_type;
  logic [4:0]  in_tag;
  logic [31:0] cur_instr;

  logic        in_ready, out_valid, imm_err;
  logic [31:0] imm_out;
  logic [4:0]  out_tag;
  logic [1:0]  count;
  logic        in_ready64, out_valid64, imm_err64;
  logic [63:0] imm_out64;
  logic [4:0]  out_tag64;
  logic [1:0]  count64;

  int errors = 0;
  int checks = 0;
  bit last_push;

  typedef struct {
    logic [63:0] v;
    logic        err;
    logic [4:0]  tag;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  imm_gen_stage #(.DATA_WIDTH(32), .DEPTH(DEPTH), .TAG_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .ImmType(imm_type), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .ImmOut(imm_out), .ImmErr(imm_err), .out_tag(out_tag),
    .count(count)
  );

  imm_gen_stage #(.DATA_WIDTH(64), .DEPTH(DEPTH), .TAG_WIDTH(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .imm(imm), .ImmType(imm_type), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .ImmOut(imm_out64), .ImmErr(imm_err64), .out_tag(out_tag64),
    .count(count64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the full instruction word using the ISA field layout.
  function automatic ent_t model(input logic [2:0] t, input logic [31:0] instr, input logic [4:0] tg);
    ent_t e;
    int   s;
    int   r;
    s     = instr;
    r     = 0;
    e.err = 1'b0;
    case (t)
      3'd0: r = s >>> 20;
      3'd1: r = ((s >>> 25) * 32) + int'((instr >> 7) & 32'h1F);
      3'd2: r = ((s >>> 31) * 4096) + int'(((instr >> 7) & 1) * 2048)
              + int'(((instr >> 25) & 63) * 32) + int'(((instr >> 8) & 15) * 2);
      3'd3: r = int'(instr & 32'hFFFF_F000);
      3'd4: r = ((s >>> 31) * 1048576) + int'(((instr >> 12) & 255) * 4096)
              + int'(((instr >> 20) & 1) * 2048) + int'(((instr >> 21) & 1023) * 2);
`ifdef IMM_ZIMM_EN
      3'd5: r = int'((instr >> 15) & 31);
`endif
      default: e.err = 1'b1;
    endcase
    e.v   = e.err ? 64'd0 : 64'(longint'(r));
    e.tag = tg;
    return e;
  endfunction

  task automatic drive(input bit v, input logic [2:0] t, input logic [31:0] instr,
                       input logic [4:0] tg, input bit ordy, input bit fl);
    in_valid  = v;
    imm_type  = t;
    cur_instr = instr;
    imm       = instr[31:7];
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Check the current outputs against the model, then advance one clock.
  task automatic cycle();
    bit   push, pop;
    ent_t e, d;
    check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    check("count", 64'(count), 64'(q.size()));
    check("count64", 64'(count64), 64'(q.size()));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() > 0) begin
      check("imm_out", 64'(imm_out), {32'd0, q[0].v[31:0]});
      check("imm_out64", imm_out64, q[0].v);
      check("imm_err", 64'(imm_err), 64'(q[0].err));
      check("out_tag", 64'(out_tag), 64'(q[0].tag));
    end
    push = in_valid && (q.size() < DEPTH) && !flush;
    pop  = out_ready && (q.size() > 0) && !flush;
    e    = model(imm_type, cur_instr, in_tag);
    @(posedge clk);
    #1;
    last_push = push;
    if (flush) q.delete();
    else begin
      if (pop) d = q.pop_front();
      if (push) q.push_back(e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 3'd0, 32'd0, 5'd0, 0, 0);
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_imm_out", 64'(imm_out), 64'd0);
    check("rst_imm_err", 64'(imm_err), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'(in_ready), 64'd1);

    drive(1, 3'd0, 32'hFFF0_0093, 5'd1, 1, 0);
    cycle();
    check("addi_imm", 64'(imm_out), 64'hFFFF_FFFF);
    check("addi_tag", 64'(out_tag), 64'd1);
    drive(1, 3'd2, 32'hFE00_0EE3, 5'd2, 1, 0);
    cycle();
    check("beq_imm", 64'(imm_out), 64'hFFFF_FFFC);
    drive(1, 3'd4, 32'h0010_006F, 5'd3, 1, 0);
    cycle();
    check("jal_imm", 64'(imm_out), 64'h0000_0800);
    drive(1, 3'd3, 32'h8000_00B7, 5'd4, 1, 0);
    cycle();
    check("lui_neg64", imm_out64, 64'hFFFF_FFFF_8000_0000);
    drive(1, 3'd3, 32'h1234_50B7, 5'd5, 1, 0);
    cycle();
    check("lui_pos64", imm_out64, 64'h0000_0000_1234_5000);
    drive(1, 3'd7, 32'hFFFF_FF80, 5'd6, 1, 0);
    cycle();
    check("illegal_imm", 64'(imm_out), 64'd0);
    check("illegal_err", 64'(imm_err), 64'd1);
    drive(1, 3'd5, 32'h000F_8000, 5'd7, 1, 0);
    cycle();
`ifdef IMM_ZIMM_EN
    check("zimm_imm", 64'(imm_out), 64'h1F);
    check("zimm_err", 64'(imm_err), 64'd0);
`else
    check("zimm_imm", 64'(imm_out), 64'd0);
    check("zimm_err", 64'(imm_err), 64'd1);
`endif
    drive(0, 3'd0, 32'd0, 5'd0, 1, 0);
    cycle();

    // Back-pressure: third beat must wait until the consumer drains.
    drive(1, 3'd1, 32'hFE11_2FA3, 5'd10, 0, 0);
    cycle();
    drive(1, 3'd0, 32'h0010_0113, 5'd11, 0, 0);
    cycle();
    check("full_count", 64'(count), 64'd2);
    check("full_in_ready", 64'(in_ready), 64'd0);
    drive(1, 3'd4, 32'hFFDF_F0EF, 5'd12, 0, 0);
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (last_push) begin
        in_valid = 1'b0;
        break;
      end
    end
    check("third_beat_accepted", 64'(last_push), 64'd1);
    for (int i = 0; i < 3; i++) cycle();

    // Flush with a concurrent push drops everything.
    drive(1, 3'd0, 32'h1230_0093, 5'd20, 0, 0);
    cycle();
    drive(1, 3'd0, 32'h4560_0093, 5'd21, 0, 0);
    cycle();
    check("pre_flush_count", 64'(count), 64'd2);
    drive(1, 3'd0, 32'h7890_0093, 5'd31, 0, 1);
    cycle();
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    drive(1, 3'd3, 32'hABCD_E037, 5'd9, 1, 0);
    cycle();
    check("post_flush_tag", 64'(out_tag), 64'd9);
    drive(0, 3'd0, 32'd0, 5'd0, 1, 0);
    cycle();

    // Asynchronous reset mid-stream.
    drive(1, 3'd2, 32'h0000_0463, 5'd13, 0, 0);
    cycle();
    drive(1, 3'd1, 32'h0011_2223, 5'd14, 0, 0);
    cycle();
    #3 rst_n = 1'b0;
    #1;
    check("async_count", 64'(count), 64'd0);
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd0);
    check("async_imm_out", 64'(imm_out), 64'd0);
    check("async_imm_err", 64'(imm_err), 64'd0);
    check("async_out_tag", 64'(out_tag), 64'd0);
    q.delete();
    drive(0, 3'd0, 32'd0, 5'd0, 0, 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom,
            5'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
      cycle();
    end
    drive(0, 3'd0, 32'd0, 5'd0, 1, 0);
    for (int i = 0; i < 3; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
